// File: rtl/flash_pkg.sv
// flash_pkg: opcodes, FSM states and opcode decode shared by the SPI flash responder.
package flash_pkg;
    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_JEDEC = 8'h9F;
    localparam logic [7:0] CMD_WAKE  = 8'hAB;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, IGNORE} state_t;

    // Wake is accepted but has nothing to send, so it parks like an unknown opcode.
    function automatic state_t decode(input logic [7:0] op);
        return (op == CMD_READ)  ? ADDR :
               (op == CMD_JEDEC) ? ID   :
               (op == CMD_WAKE)  ? IGNORE : IGNORE;
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizers for an SPI slave plus sclk rise/fall and cs fall pulses.
module spi_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic i_cs,
    input  logic i_sclk,
    input  logic i_mosi,
    output logic o_cs,
    output logic o_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_fall
);
    logic [1:0] r_cs, r_sclk, r_mosi;
    logic       r_sclk_d, r_cs_d;

    // cs resets to its idle-high level so no false select appears out of reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs     <= 2'b11;
            r_sclk   <= 2'b00;
            r_mosi   <= 2'b00;
            r_sclk_d <= 1'b0;
            r_cs_d   <= 1'b1;
        end else begin
            r_cs     <= {r_cs[0], i_cs};
            r_sclk   <= {r_sclk[0], i_sclk};
            r_mosi   <= {r_mosi[0], i_mosi};
            r_sclk_d <= r_sclk[1];
            r_cs_d   <= r_cs[1];
        end
    end

    assign o_cs        = r_cs[1];
    assign o_mosi      = r_mosi[1];
    assign o_sclk_rise = r_sclk[1] & ~r_sclk_d;
    assign o_sclk_fall = ~r_sclk[1] & r_sclk_d;
    assign o_cs_fall   = ~r_cs[1] & r_cs_d;
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 NOR flash emulator (READ, JEDEC ID, wake) backed by a
// synchronous byte-wide store with one clk read latency.
module spi_flash_responder
    import flash_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4016
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  spi_cs,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rd,
    input  logic [7:0]            mem_rdata,
    output logic                  busy
);
    logic        w_cs, w_mosi, w_rise, w_fall, w_cs_fall;
    logic [23:0] w_word;
    state_t      r_state;
    logic [4:0]  r_bit_cnt;
    logic [22:0] r_shift;
    logic [23:0] r_tx;
    logic [7:0]  r_next;
    logic        r_load;

    spi_sync_edge u_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_cs        (spi_cs),
        .i_sclk      (spi_sclk),
        .i_mosi      (spi_mosi),
        .o_cs        (w_cs),
        .o_mosi      (w_mosi),
        .o_sclk_rise (w_rise),
        .o_sclk_fall (w_fall),
        .o_cs_fall   (w_cs_fall)
    );

    assign w_word = {r_shift, w_mosi};
    assign busy   = ~w_cs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_next      <= '0;
            r_load      <= 1'b0;
            spi_miso    <= 1'b0;
            mem_address <= '0;
            mem_rd      <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            // rdata is valid the clk after the strobe, so capture it one clk later
            r_load <= mem_rd;
            if (r_load) r_next <= mem_rdata;
            if (w_rise) r_shift <= w_word[22:0];
            if (w_cs) begin
                r_state   <= IDLE;
                r_bit_cnt <= '0;
                spi_miso  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: if (w_cs_fall) begin
                        r_state   <= CMD;
                        r_bit_cnt <= '0;
                    end
                    CMD: if (w_rise) begin
                        r_bit_cnt <= (r_bit_cnt == 5'd7) ? 5'd0 : r_bit_cnt + 5'd1;
                        r_tx      <= JEDEC_ID;
                        if (r_bit_cnt == 5'd7) r_state <= decode(w_word[7:0]);
                    end
                    ADDR: if (w_rise) begin
                        r_bit_cnt <= (r_bit_cnt == 5'd23) ? 5'd0 : r_bit_cnt + 5'd1;
                        if (r_bit_cnt == 5'd23) begin
                            mem_address <= w_word[ADDR_WIDTH-1:0];
                            mem_rd      <= 1'b1;
                            r_state     <= DATA;
                        end
                    end
                    // Byte boundary: send the prefetched byte and fetch the one after it.
                    DATA: if (w_fall) begin
                        r_bit_cnt <= {2'b00, r_bit_cnt[2:0] + 3'd1};
                        if (r_bit_cnt[2:0] == 3'd0) begin
                            spi_miso    <= r_next[7];
                            r_tx        <= {r_next[6:0], 17'd0};
                            mem_address <= mem_address + ADDR_WIDTH'(1);
                            mem_rd      <= 1'b1;
                        end else begin
                            spi_miso <= r_tx[23];
                            r_tx     <= {r_tx[22:0], 1'b0};
                        end
                    end
                    // Zeros shift in behind the ID, so the bus reads 0 once it is sent.
                    ID: if (w_fall) begin
                        spi_miso <= r_tx[23];
                        r_tx     <= {r_tx[22:0], 1'b0};
                    end
                    default: spi_miso <= 1'b0;
                endcase
            end
        end
    end
endmodule
